// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Operand/result handshake bundle for serial_subtractor.
//   Operand channel : in_valid, in_ready, a, b, bin
//   Result channel  : out_valid, out_ready, diff, bout, ovf, zero
// Modports:
//   master - operand producer / result consumer
//   slave  - the subtractor itself
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Digit-serial WIDTH-bit subtractor computing a - b - bin, DIGIT bits per
// cycle with a registered borrow between digits.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - serial_subtractor_if.slave: operand handshake (in_valid/in_ready,
//          a, b, bin) and result handshake (out_valid/out_ready, diff, bout,
//          ovf, zero). All outputs come straight from registers.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accept edge.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int unsigned NDig    = WIDTH / DIGIT;
    localparam int unsigned CntW    = (NDig > 1) ? $clog2(NDig) : 1;
    localparam int unsigned SliceW  = DIGIT + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NDig - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              borrow_q;
    logic [WIDTH-1:0]  acc_q;

    // Registered outputs
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  diff_q;
    logic              bout_q;
    logic              ovf_q;
    logic              zero_q;

    // Digit slice and next-state values
    int unsigned       base;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic              not_borrow;
    logic [SliceW-1:0] slice;
    logic              borrow_d;
    logic [WIDTH-1:0]  acc_d;
    logic              ovf_d;
    logic              zero_d;

    always_comb begin
        base       = int'(cnt_q) * DIGIT;
        a_dig      = a_q[base +: DIGIT];
        b_dig      = b_q[base +: DIGIT];
        // Subtract as a + ~b + carry-in, where carry-in is the inverted borrow.
        not_borrow = ~borrow_q;
        slice      = {1'b0, a_dig} + {1'b0, ~b_dig} + SliceW'(not_borrow);
        borrow_d   = ~slice[DIGIT];
        acc_d      = acc_q;
        acc_d[base +: DIGIT] = slice[DIGIT-1:0];
        // Only meaningful on the last digit, when acc_d holds the full result.
        ovf_d      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
        zero_d     = (acc_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        borrow_q   <= bus.bin;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        // Result registers only change here, so they hold
                        // steady through DONE and after the handshake.
                        diff_q      <= acc_d;
                        bout_q      <= borrow_d;
                        ovf_q       <= ovf_d;
                        zero_q      <= zero_d;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed vector table plus hand-written handshake/reset sequences on a
// DIGIT=8 instance, and a random sweep across DIGIT=1, 8 and 32 instances
// driven in parallel against an a - b - bin reference.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    serial_subtractor_if #(.WIDTH(32)) if1 ();
    serial_subtractor_if #(.WIDTH(32)) if8 ();
    serial_subtractor_if #(.WIDTH(32)) if32 ();

    serial_subtractor #(.WIDTH(32), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .bus(if1.slave));
    serial_subtractor #(.WIDTH(32), .DIGIT(8))  u_d8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_subtractor #(.WIDTH(32), .DIGIT(32)) u_d32 (.clk(clk), .rst(rst), .bus(if32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full operation on the DIGIT=8 instance, including the result handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          output logic [31:0] d, output logic bo, output logic ov,
                          output logic z, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", if8.in_ready, 1);
        if8.a = a;
        if8.b = b;
        if8.bin = bi;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (if8.out_valid) break;
            check("in_ready_low_in_run", if8.in_ready, 0);
        end
        check("out_valid_seen", if8.out_valid, 1);
        d  = if8.diff;
        bo = if8.bout;
        ov = if8.ovf;
        z  = if8.zero;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
        check("out_valid_after_hs", if8.out_valid, 0);
        check("in_ready_after_hs", if8.in_ready, 1);
    endtask

    task automatic wait_out_valid8();
        for (int i = 0; i < 20; i++) begin
            if (if8.out_valid) break;
            @(posedge clk);
            #1;
        end
        check("wait_out_valid", if8.out_valid, 1);
    endtask

    logic [31:0] d;
    logic        bo, ov, z;
    int          lat;

    initial begin
        vecs[0]  = '{32'd100,       32'd58,        1'b0, 32'd42,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'd0,         32'd1,         1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h80000000, 32'd1,         1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h01000000, 32'd1,         1'b0, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'd5,         32'd4,         1'b1, 32'd0,         1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'd0,         32'd0,         1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'd7,         32'd3,         1'b0, 32'd4,         1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'd0,         1'b0, 1'b1, 1'b1};
        vecs[10] = '{32'h12345678, 32'h12345679, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h00000100, 32'd1,         1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};

        if1.in_valid = 0;  if1.a = 0;  if1.b = 0;  if1.bin = 0;  if1.out_ready = 0;
        if8.in_valid = 0;  if8.a = 0;  if8.b = 0;  if8.bin = 0;  if8.out_ready = 0;
        if32.in_valid = 0; if32.a = 0; if32.b = 0; if32.bin = 0; if32.out_ready = 0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", if8.in_ready, 1);
        check("rst_out_valid", if8.out_valid, 0);
        check("rst_diff", if8.diff, 0);
        check("rst_bout", if8.bout, 0);
        check("rst_ovf", if8.ovf, 0);
        check("rst_zero", if8.zero, 0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, z, lat);
            check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
            check($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
            check($sformatf("vec%0d_zero", i), z, vecs[i].zero);
            check($sformatf("vec%0d_latency", i), lat, 4);
        end

        // Backpressure with new operands offered during DONE
        @(negedge clk);
        if8.a = 32'd1000; if8.b = 32'd1; if8.bin = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        wait_out_valid8();
        for (int i = 0; i < 10; i++) begin
            if8.a = 32'd55; if8.b = 32'd5; if8.bin = 1'b0; if8.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid", if8.out_valid, 1);
            check("bp_in_ready", if8.in_ready, 0);
            check("bp_diff", if8.diff, 32'd999);
            check("bp_bout", if8.bout, 0);
            check("bp_ovf", if8.ovf, 0);
            check("bp_zero", if8.zero, 0);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
        check("bp_release_out_valid", if8.out_valid, 0);
        check("bp_release_in_ready", if8.in_ready, 1);
        check("bp_release_diff_held", if8.diff, 32'd999);
        run_op(32'd55, 32'd5, 1'b0, d, bo, ov, z, lat);
        check("bp_next_diff", d, 32'd50);
        check("bp_next_latency", lat, 4);

        // Reset during the 2nd RUN cycle
        @(negedge clk);
        if8.a = 32'd9; if8.b = 32'd2; if8.bin = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", if8.in_ready, 1);
        check("midrst_out_valid", if8.out_valid, 0);
        check("midrst_diff", if8.diff, 0);
        begin
            logic spurious;
            spurious = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (if8.out_valid) spurious = 1'b1;
            end
            check("midrst_no_spurious_valid", spurious, 0);
        end
        run_op(32'd7, 32'd3, 1'b0, d, bo, ov, z, lat);
        check("midrst_next_diff", d, 32'd4);

        // Reset while holding a result in DONE
        @(negedge clk);
        if8.a = 32'd20; if8.b = 32'd10; if8.bin = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        wait_out_valid8();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("donerst_out_valid", if8.out_valid, 0);
        check("donerst_in_ready", if8.in_ready, 1);

        // DIGIT sweep: all three instances run the same random operands
        if1.out_ready = 1'b1;
        if8.out_ready = 1'b1;
        if32.out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            logic [31:0] ra, rb, ed;
            logic        rbi, ebo, eov, ez;
            logic [32:0] full;
            logic        got1, got8, got32;
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {32'd0, rbi};
            ed  = full[31:0];
            ebo = full[32];
            eov = (ra[31] != rb[31]) && (ed[31] != ra[31]);
            ez  = (ed == 32'd0);
            @(negedge clk);
            if1.a = ra;  if1.b = rb;  if1.bin = rbi;  if1.in_valid = 1'b1;
            if8.a = ra;  if8.b = rb;  if8.bin = rbi;  if8.in_valid = 1'b1;
            if32.a = ra; if32.b = rb; if32.bin = rbi; if32.in_valid = 1'b1;
            @(posedge clk);
            #1;
            if1.in_valid = 1'b0;
            if8.in_valid = 1'b0;
            if32.in_valid = 1'b0;
            got1 = 1'b0; got8 = 1'b0; got32 = 1'b0;
            for (int c = 1; c <= 64 && !(got1 && got8 && got32); c++) begin
                @(posedge clk);
                #1;
                if (!got1 && if1.out_valid) begin
                    got1 = 1'b1;
                    check("sweep_d1_latency", c, 32);
                    check("sweep_d1_diff", if1.diff, ed);
                    check("sweep_d1_bout", if1.bout, ebo);
                    check("sweep_d1_ovf", if1.ovf, eov);
                    check("sweep_d1_zero", if1.zero, ez);
                end
                if (!got8 && if8.out_valid) begin
                    got8 = 1'b1;
                    check("sweep_d8_latency", c, 4);
                    check("sweep_d8_diff", if8.diff, ed);
                    check("sweep_d8_bout", if8.bout, ebo);
                    check("sweep_d8_ovf", if8.ovf, eov);
                    check("sweep_d8_zero", if8.zero, ez);
                end
                if (!got32 && if32.out_valid) begin
                    got32 = 1'b1;
                    check("sweep_d32_latency", c, 1);
                    check("sweep_d32_diff", if32.diff, ed);
                    check("sweep_d32_bout", if32.bout, ebo);
                    check("sweep_d32_ovf", if32.ovf, eov);
                    check("sweep_d32_zero", if32.zero, ez);
                end
            end
            check("sweep_d1_done", got1, 1);
            check("sweep_d8_done", got8, 1);
            check("sweep_d32_done", got32, 1);
            repeat (2) @(posedge clk);
            #1;
            check("sweep_d1_idle", if1.in_ready, 1);
        end
        if1.out_ready = 1'b0;
        if8.out_ready = 1'b0;
        if32.out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
